aha_tlx_pulse_pacer: RTL and testbench



---
 rtl/aha_tlx_pulse_pacer_pkg.sv | 18 +
 rtl/aha_tlx_pulse_pacer_if.sv | 25 ++
 rtl/aha_tlx_pulse_pacer_sat_counter.sv | 47 ++++
 rtl/aha_tlx_pulse_pacer.sv | 114 +++++++++++
 tb/tb_aha_tlx_pulse_pacer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/aha_tlx_pulse_pacer_pkg.sv
// Shared definitions for the TLX pulse pacer: FSM state encoding and limits.
package aha_tlx_pkg;

  // Pacer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pacer_state_e;

  // Smallest legal spacing between pulse rising edges; one PULSE cycle plus
  // at least one GAP cycle so the synchronizer sees a low between events.
  localparam int MIN_GAP_MIN = 2;

  // Largest legal spacing; the inline gap counter is 8 bits wide.
  localparam int MIN_GAP_MAX = 255;

endpackage

// File: rtl/aha_tlx_pulse_pacer_if.sv
// Event-side signal bundle of the pulse pacer. The master drives event
// requests and control strobes; the slave (the pacer) drives status back.
interface aha_tlx_pulse_pacer_if #(
  parameter int CNT_WIDTH = 4
);

  logic                 EVENT_IN;
  logic                 FLUSH;
  logic                 OVERFLOW_CLR;
  logic                 PULSE_OUT;
  logic [CNT_WIDTH-1:0] PENDING;
  logic                 BUSY;
  logic                 OVERFLOW;

  modport master (
    output EVENT_IN, FLUSH, OVERFLOW_CLR,
    input  PULSE_OUT, PENDING, BUSY, OVERFLOW
  );

  modport slave (
    input  EVENT_IN, FLUSH, OVERFLOW_CLR,
    output PULSE_OUT, PENDING, BUSY, OVERFLOW
  );

endinterface

// File: rtl/aha_tlx_pulse_pacer_sat_counter.sv
// Saturating up/down counter with synchronous clear. Clear is applied first,
// then inc/dec; inc and dec together leave the (cleared) value unchanged.
// ovf_attempt flags an increment that was dropped because the count was full.
module aha_tlx_sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             ovf_attempt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] base;

  // Next-count decode: clear, then saturating increment/decrement.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    base        = clr ? '0 : count;
    count_next  = base;
    ovf_attempt = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (base == CNT_MAX) ovf_attempt = 1'b1;
        else                 count_next  = base + CNT_ONE;
      end
      2'b01: begin
        if (base != '0) count_next = base - CNT_ONE;
      end
      default: ;
    endcase
  end

  // Count register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) count <= '0;
    else         count <= count_next;
  end

endmodule

// File: rtl/aha_tlx_pulse_pacer.sv
// Source-domain event pacer feeding a TLX pulse synchronizer. Queues event
// requests in a saturating counter and releases them as single-cycle pulses
// whose rising edges are at least MIN_GAP cycles apart.
module aha_tlx_pulse_pacer
  import aha_tlx_pkg::*;
#(
  parameter int CNT_WIDTH = 4,
  parameter int MIN_GAP   = 4
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  aha_tlx_pulse_pacer_if.slave bus
);

  // Illegal parameters stop elaboration.
  if (MIN_GAP < MIN_GAP_MIN || MIN_GAP > MIN_GAP_MAX || CNT_WIDTH < 1) begin : g_param_check
    $fatal(1, "aha_tlx_pulse_pacer: MIN_GAP must be 2..255 and CNT_WIDTH >= 1");
  end

  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - MIN_GAP_MIN);

  pacer_state_e         state;
  logic [7:0]           gap_cnt;
  logic                 pulse_q;
  logic                 busy_q;
  logic                 overflow_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf_attempt;
  logic                 eff_nonzero;
  logic                 launch;

  // Pending count after this cycle's FLUSH/EVENT_IN is nonzero; a launch may
  // only take from events that survive a same-cycle flush.
  assign eff_nonzero = bus.EVENT_IN || (!bus.FLUSH && (cnt != '0));
  assign launch      = eff_nonzero &&
                       ((state == IDLE) || ((state == GAP) && (gap_cnt == '0)));

  aha_tlx_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_pending (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .clr         (bus.FLUSH),
    .inc         (bus.EVENT_IN),
    .dec         (launch),
    .count       (cnt),
    .count_next  (cnt_next),
    .ovf_attempt (ovf_attempt)
  );

  // Pacing FSM with registered PULSE_OUT/BUSY and sticky overflow flag.
  always_ff @(posedge CLK or negedge RESETn) begin
    // NOTE: the asynchronous reset branch clears every flop, so PULSE_OUT
    // drops the moment RESETn falls rather than at the next clock edge.
    if (!RESETn) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every branch reads
      // the pre-edge values, independent of statement order.
      if (ovf_attempt)           overflow_q <= 1'b1;
      else if (bus.OVERFLOW_CLR) overflow_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (launch) begin
            state   <= PULSE;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            pulse_q <= 1'b0;
            busy_q  <= (cnt_next != '0);
          end
        end
        PULSE: begin
          state   <= GAP;
          gap_cnt <= GAP_LOAD;
          pulse_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 8'd1;
            pulse_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (launch) begin
            state   <= PULSE;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state   <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= (cnt_next != '0);
          end
        end
        default: begin
          state   <= IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PULSE_OUT = pulse_q;
  assign bus.PENDING   = cnt;
  assign bus.BUSY      = busy_q;
  assign bus.OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_aha_tlx_pulse_pacer.sv
// Directed bench for aha_tlx_pulse_pacer. Instance A (CNT_WIDTH=4) covers
// latency, burst spacing, flush and reset; instance B (CNT_WIDTH=2) covers
// saturation and the sticky overflow flag. Both use MIN_GAP=4.
// Step k below means "sampled 1 ns after the k-th clock edge that sees the
// stimulus"; a pulse launched at edge k is visible at step k.
module tb_aha_tlx_pulse_pacer;

  logic CLK;
  logic RESETn;

  int checks = 0;
  int errors = 0;
  int npulse;

  aha_tlx_pulse_pacer_if #(.CNT_WIDTH(4)) if_a ();
  aha_tlx_pulse_pacer_if #(.CNT_WIDTH(2)) if_b ();

  aha_tlx_pulse_pacer #(.CNT_WIDTH(4), .MIN_GAP(4)) dut_a (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (if_a)
  );

  aha_tlx_pulse_pacer #(.CNT_WIDTH(2), .MIN_GAP(4)) dut_b (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (if_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Burst of 5 events from idle: launches at steps 1,5,9,13,17; the launch at
  // step 1 and step 5 each absorb that cycle's event.
  logic [21:0] burst_pulse_map;
  int          burst_pend [21] = '{0, 1, 2, 3, 3, 3, 3, 3, 2, 2, 2,
                                   2, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    burst_pulse_map = 22'h022222;
    RESETn = 1'b0;
    if_a.EVENT_IN = 1'b0; if_a.FLUSH = 1'b0; if_a.OVERFLOW_CLR = 1'b0;
    if_b.EVENT_IN = 1'b0; if_b.FLUSH = 1'b0; if_b.OVERFLOW_CLR = 1'b0;
    repeat (3) step();

    // Reset values.
    check("rst_a_pulse",    32'(if_a.PULSE_OUT), 32'd0);
    check("rst_a_pending",  32'(if_a.PENDING),   32'd0);
    check("rst_a_busy",     32'(if_a.BUSY),      32'd0);
    check("rst_a_overflow", 32'(if_a.OVERFLOW),  32'd0);
    check("rst_b_pulse",    32'(if_b.PULSE_OUT), 32'd0);
    check("rst_b_pending",  32'(if_b.PENDING),   32'd0);
    RESETn = 1'b1;
    repeat (2) step();

    // Single event: one-cycle latency, one pulse, BUSY low MIN_GAP later.
    if_a.EVENT_IN = 1'b1;
    step();
    if_a.EVENT_IN = 1'b0;
    check("single_pulse_k1",   32'(if_a.PULSE_OUT), 32'd1);
    check("single_pending_k1", 32'(if_a.PENDING),   32'd0);
    check("single_busy_k1",    32'(if_a.BUSY),      32'd1);
    npulse = 0;
    for (int k = 2; k <= 5; k++) begin
      step();
      npulse += int'(if_a.PULSE_OUT);
    end
    check("single_extra_pulses", 32'(npulse),     32'd0);
    check("single_busy_k5",      32'(if_a.BUSY),  32'd0);

    // Burst of 5: pulses every 4 cycles, pending trace, no overflow.
    npulse = 0;
    for (int k = 1; k <= 21; k++) begin
      if_a.EVENT_IN = (k <= 5);
      step();
      npulse += int'(if_a.PULSE_OUT);
      check($sformatf("burst_pulse_k%0d", k), 32'(if_a.PULSE_OUT), 32'(burst_pulse_map[k]));
      check($sformatf("burst_pending_k%0d", k), 32'(if_a.PENDING), 32'(burst_pend[k-1]));
    end
    if_a.EVENT_IN = 1'b0;
    check("burst_total",    32'(npulse),         32'd5);
    check("burst_overflow", 32'(if_a.OVERFLOW),  32'd0);
    check("burst_busy_end", 32'(if_a.BUSY),      32'd0);

    // FLUSH with 3 pending during GAP (gap counter at 0 after step 4).
    for (int k = 1; k <= 4; k++) begin
      if_a.EVENT_IN = 1'b1;
      step();
    end
    if_a.EVENT_IN = 1'b0;
    check("flush_pending_before", 32'(if_a.PENDING), 32'd3);
    if_a.FLUSH = 1'b1;
    step();
    if_a.FLUSH = 1'b0;
    check("flush_pending_after", 32'(if_a.PENDING),   32'd0);
    check("flush_pulse_after",   32'(if_a.PULSE_OUT), 32'd0);
    check("flush_busy_after",    32'(if_a.BUSY),      32'd0);
    npulse = 0;
    repeat (8) begin
      step();
      npulse += int'(if_a.PULSE_OUT);
    end
    check("flush_no_more_pulses", 32'(npulse), 32'd0);

    // FLUSH + EVENT_IN together mid-GAP: exactly one pending, launched when
    // the gap expires (4 cycles after the previous pulse).
    for (int k = 1; k <= 3; k++) begin
      if_a.EVENT_IN = 1'b1;
      step();
      if (k == 1) check("fe_first_pulse", 32'(if_a.PULSE_OUT), 32'd1);
    end
    check("fe_pending_k3", 32'(if_a.PENDING), 32'd2);
    if_a.FLUSH = 1'b1;
    step();
    if_a.FLUSH = 1'b0;
    if_a.EVENT_IN = 1'b0;
    check("fe_pending_k4", 32'(if_a.PENDING),   32'd1);
    check("fe_pulse_k4",   32'(if_a.PULSE_OUT), 32'd0);
    step();
    check("fe_pulse_k5",   32'(if_a.PULSE_OUT), 32'd1);
    check("fe_pending_k5", 32'(if_a.PENDING),   32'd0);
    npulse = 0;
    repeat (8) begin
      step();
      npulse += int'(if_a.PULSE_OUT);
    end
    check("fe_no_more_pulses", 32'(npulse),    32'd0);
    check("fe_busy_end",       32'(if_a.BUSY), 32'd0);

    // Saturation on B (max 3): 6 events. Launch at step 1, event+launch at
    // step 5 while full (retained, no overflow), event at step 6 dropped.
    npulse = 0;
    for (int k = 1; k <= 22; k++) begin
      if_b.EVENT_IN = (k <= 6);
      step();
      npulse += int'(if_b.PULSE_OUT);
      if (k == 4) check("sat_pending_k4", 32'(if_b.PENDING), 32'd3);
      if (k == 5) begin
        check("sat_launch_pending_k5",  32'(if_b.PENDING),   32'd3);
        check("sat_launch_overflow_k5", 32'(if_b.OVERFLOW),  32'd0);
        check("sat_launch_pulse_k5",    32'(if_b.PULSE_OUT), 32'd1);
      end
      if (k == 6) begin
        check("sat_pending_k6",  32'(if_b.PENDING),  32'd3);
        check("sat_overflow_k6", 32'(if_b.OVERFLOW), 32'd1);
      end
    end
    if_b.EVENT_IN = 1'b0;
    check("sat_total_pulses", 32'(npulse),         32'd5);
    check("sat_pending_end",  32'(if_b.PENDING),   32'd0);
    check("sat_overflow_sticky", 32'(if_b.OVERFLOW), 32'd1);
    check("sat_busy_end",     32'(if_b.BUSY),      32'd0);
    if_b.OVERFLOW_CLR = 1'b1;
    step();
    if_b.OVERFLOW_CLR = 1'b0;
    check("sat_overflow_cleared", 32'(if_b.OVERFLOW), 32'd0);

    // Overflow set and clear in the same cycle: set wins.
    for (int k = 1; k <= 6; k++) begin
      if_b.EVENT_IN = 1'b1;
      if_b.OVERFLOW_CLR = (k == 6);
      step();
      if (k == 5) check("setclr_overflow_k5", 32'(if_b.OVERFLOW), 32'd0);
    end
    if_b.EVENT_IN = 1'b0;
    if_b.OVERFLOW_CLR = 1'b0;
    check("setclr_overflow_k6", 32'(if_b.OVERFLOW), 32'd1);
    repeat (16) step();
    check("setclr_pending_drained", 32'(if_b.PENDING), 32'd0);
    if_b.OVERFLOW_CLR = 1'b1;
    step();
    if_b.OVERFLOW_CLR = 1'b0;
    check("setclr_overflow_cleared", 32'(if_b.OVERFLOW), 32'd0);

    // Reset while PULSE_OUT=1 with a backlog on A.
    for (int k = 1; k <= 5; k++) begin
      if_a.EVENT_IN = 1'b1;
      step();
    end
    if_a.EVENT_IN = 1'b0;
    check("rstmid_pulse_before",   32'(if_a.PULSE_OUT), 32'd1);
    check("rstmid_pending_before", 32'(if_a.PENDING),   32'd3);
    #2;
    RESETn = 1'b0;
    #1;
    check("rstmid_pulse_async", 32'(if_a.PULSE_OUT), 32'd0);
    check("rstmid_pending",     32'(if_a.PENDING),   32'd0);
    check("rstmid_busy",        32'(if_a.BUSY),      32'd0);
    step();
    #2;
    RESETn = 1'b1;
    step();
    check("rstmid_idle_after", 32'(if_a.PULSE_OUT), 32'd0);
    if_a.EVENT_IN = 1'b1;
    step();
    if_a.EVENT_IN = 1'b0;
    check("rstmid_latency_pulse",   32'(if_a.PULSE_OUT), 32'd1);
    check("rstmid_latency_pending", 32'(if_a.PENDING),   32'd0);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
